bcd_seg7_display: RTL and testbench
===================================

// Module: bcd_seg7_display
// PURPOSE
//  Reads the 4-digit packed BCD value from the BCD register and drives a 4-digit, common-anode,
//  time-multiplexed 7-segment display.
//  - Captures a new value on each rising edge of new_data_triger.
//  - Applies the captured value only at a frame boundary, so one scan frame never shows mixed old and new digits.
//  - Supports leading-zero blanking, invalid-digit indication and an optional decimal point.
// PARAMETERS
//  DIGIT_TICKS   100_000  clk cycles per digit slot (4 slots = 1 frame); legal range >= GAP_TICKS+1
//  GAP_TICKS     1_000    cycles at start of each slot with all anodes off (anti-ghosting); legal range >= 1
//  DP_DIGIT      4        digit index (0 = LSD) that lights the decimal point; 4 = no decimal point
// PORTS
//  clk              in   1   system clock
//  rst              in   1   synchronous reset, active-high
//  bcd_values       in   16  packed BCD: [15:12]=d3 (MSD) .. [3:0]=d0 (LSD)
//  new_data_triger  in   1   level from producer; each rising edge samples bcd_values
//  blank_lz         in   1   1 = blank leading zeros
//  seg_n            out  7   {g,f,e,d,c,b,a}, active-low
//  dp_n             out  1   decimal point, active-low
//  an_n             out  4   digit anodes, active-low, an_n[i] = digit i
//  frame_strobe     out  1   1-cycle pulse when a new frame starts (digit 0, tick 0)
//  update_pending   out  1   a captured value is waiting for the next frame boundary
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge). Reset value of every output and state register:
//    - counters: tick=0, digit=0
//    - value registers: display=0, pending=0, pend_v=0, trig_q=0
//    - outputs: an_n=4'hF, seg_n=7'h7F, dp_n=1, frame_strobe=0, update_pending=0
//    - reset mid-frame aborts the scan and discards any pending value
//  - Scan counter
//    - tick counts 0..DIGIT_TICKS-1.
//    - On wrap, digit increments; digit 3 wraps to 0.
//    - The frame boundary is a tick wrap with digit==3.
//  - Per-slot state machine: GAP (tick<GAP_TICKS) -> ON (tick>=GAP_TICKS) -> GAP of the next digit.
//    - GAP: an_n=4'hF, seg_n=7'h7F, dp_n=1.
//    - ON: an_n=~(1<<digit); seg_n/dp_n drive the current digit.
//  - All outputs are registered: 1-cycle latency from tick/digit state to the pins.
//  - Capture: rise = new_data_triger & ~trig_q. On rise: pending<=bcd_values, pend_v<=1.
//    - Several rises within one frame: the last one wins.
//  - Apply: at the frame boundary, if pend_v=1: display<=pending, pend_v<=0.
//    - If rise coincides with the boundary, the bcd_values sampled that cycle go straight to display and pend_v stays 0.
//  - update_pending = pend_v, registered.
//  - frame_strobe is asserted in the same output cycle as the first GAP output of digit 0.
//    - No strobe on the first frame after reset.
//  - Digit decode (nibble 0-9): standard glyphs.
//    - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
//    - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
//    - Nibble A-F (invalid BCD) -> dash 0111111; never blanked.
//  - Leading-zero blanking (blank_lz=1): digit i (i=3..1) shows 1111111 if it and every higher digit equals 0.
//    - Digit 0 is never blanked.
//    - Digits <= DP_DIGIT are never blanked.
//    - blank_lz is sampled live, not framed.
//  - dp_n=0 only in the ON phase of digit==DP_DIGIT.
// STRUCTURE
//  - Shared package seg7_pkg:
//    - SEG_BLANK=7'h7F, SEG_DASH=7'h3F, digit glyph table localparam array
//    - typedef enum {SLOT_GAP, SLOT_ON} slot_state_t
//    - function bcd_to_seg(nibble) -> seg_n
//  - One combinational sub-module seg7_decoder (nibble, blank -> seg_n).
//  - Everything else (scan counter, capture/apply, LZ logic, output regs) stays in this module.
// TESTING (DIGIT_TICKS=8, GAP_TICKS=2, DP_DIGIT=4; frame=32 cycles)
//  1. Reset: hold rst 3 cycles, then release.
//     -> an_n=F, seg_n=7F, dp_n=1 during reset; first an_n=E appears at cycle 3 after release.
//  2. bcd_values=16'h1234, pulse trigger, wait 2 frames.
//     -> d0 slot seg_n=0011001 ('4'), d3 slot seg_n=1111001 ('1'); anodes off 2 cycles per slot.
//  3. Display 1234; mid-frame (digit 1) load 16'h5678.
//     -> rest of frame still shows 1234; update_pending=1 until boundary; next frame shows 5678.
//  4. blank_lz=1, load 16'h0007, then 16'h0000.
//     -> d3..d1 seg_n=7F, d0 '7'; then only d0 lit as '0'; repeat with DP_DIGIT=1: d1 shows '0'.
//  5. Load 16'h12A4.
//     -> d1 slot seg_n=0111111 (dash); other digits normal.
//  6. Trigger rise exactly on boundary cycle with 16'h9999, plus rst asserted in the middle of a later frame.
//     -> 9999 shown from that frame; update_pending never 1; rst returns all outputs to reset values next cycle.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants, glyph table and slot-state type for the 7-segment display path.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // {g,f,e,d,c,b,a}, active-low, index = decimal digit
    localparam logic [6:0] SEG_GLYPH [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef enum logic {
        SLOT_GAP,
        SLOT_ON
    } slot_state_t;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        if (nibble <= 4'd9) begin
            seg = SEG_GLYPH[nibble];
        end else begin
            seg = SEG_DASH;
        end
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational nibble-to-segment decoder; blank forces all segments off.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = bcd_to_seg(nibble);
        if (blank) begin
            seg_n = SEG_BLANK;
        end
    end

endmodule

// File: rtl/bcd_seg7_display.sv
// 4-digit common-anode multiplexed display driver with frame-synchronous value update.
//   state    | meaning
//   SLOT_GAP | first GAP_TICKS of a digit slot, all anodes off
//   SLOT_ON  | remainder of the slot, current digit driven
module bcd_seg7_display
    import seg7_pkg::*;
#(
    parameter int DIGIT_TICKS = 100_000,
    parameter int GAP_TICKS   = 1_000,
    parameter int DP_DIGIT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd_values,
    input  logic        new_data_triger,
    input  logic        blank_lz,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [3:0]  an_n,
    output logic        frame_strobe,
    output logic        update_pending
);

    localparam int              TW        = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam logic [TW-1:0]   TICK_LAST = TW'(DIGIT_TICKS - 1);
    localparam logic [TW-1:0]   GAP_END   = TW'(GAP_TICKS);
    localparam bit              DP_EN     = (DP_DIGIT >= 0) && (DP_DIGIT <= 3);
    localparam logic [1:0]      DP_IDX    = 2'(DP_DIGIT);

    logic [TW-1:0] tick_q, tick_d;
    logic [1:0]    digit_q, digit_d;
    slot_state_t   slot_q, slot_d;
    logic [15:0]   display_q, display_d;
    logic [15:0]   pending_q, pending_d;
    logic          pend_v_q, pend_v_d;
    logic          trig_q, trig_d;
    logic          started_q, started_d;

    logic [3:0]    an_n_q, an_n_d;
    logic [6:0]    seg_n_q, seg_n_d;
    logic          dp_n_q, dp_n_d;
    logic          frame_strobe_q, frame_strobe_d;
    logic          update_pending_q, update_pending_d;

    logic          tick_wrap;
    logic          boundary;
    logic          rise;
    logic [3:0]    digit_zero;
    logic [3:0]    blank_vec;
    logic [3:0]    cur_nibble;
    logic          cur_blank;
    logic [6:0]    dec_seg_n;

    assign tick_wrap = (tick_q == TICK_LAST);
    assign boundary  = tick_wrap && (digit_q == 2'd3);
    assign rise      = new_data_triger && !trig_q;

    always_comb begin
        tick_d    = tick_wrap ? '0 : tick_q + TW'(1);
        digit_d   = tick_wrap ? digit_q + 2'd1 : digit_q;
        started_d = started_q || boundary;
    end

    // A rise on the boundary cycle bypasses the pending slot entirely.
    always_comb begin
        trig_d    = new_data_triger;
        display_d = display_q;
        pending_d = pending_q;
        pend_v_d  = pend_v_q;
        if (boundary) begin
            if (rise) begin
                display_d = bcd_values;
                pend_v_d  = 1'b0;
            end else if (pend_v_q) begin
                display_d = pending_q;
                pend_v_d  = 1'b0;
            end
        end else if (rise) begin
            pending_d = bcd_values;
            pend_v_d  = 1'b1;
        end
    end

    // Leading-zero run from the MSD down; with a decimal point enabled, digits at or
    // right of the point keep their zero so values like "0.05" stay readable.
    always_comb begin
        logic lz_run;
        lz_run    = blank_lz;
        blank_vec = '0;
        for (int i = 0; i < 4; i++) begin
            digit_zero[i] = (display_q[4*i +: 4] == 4'd0);
        end
        for (int i = 3; i >= 0; i--) begin
            lz_run       = lz_run && digit_zero[i];
            blank_vec[i] = lz_run && (i != 0) && (!DP_EN || (i > DP_DIGIT));
        end
    end

    assign cur_nibble = display_q[{digit_q, 2'b00} +: 4];
    assign cur_blank  = blank_vec[digit_q];

    seg7_decoder u_dec (
        .nibble (cur_nibble),
        .blank  (cur_blank),
        .seg_n  (dec_seg_n)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= SLOT_GAP;
        end else begin
            slot_q <= slot_d;
        end
    end

    always_comb begin
        slot_d = slot_q;
        case (slot_q)
            SLOT_GAP: if (tick_d >= GAP_END) slot_d = SLOT_ON;
            SLOT_ON:  if (tick_wrap)         slot_d = SLOT_GAP;
            default:                         slot_d = SLOT_GAP;
        endcase
    end

    always_comb begin
        an_n_d  = 4'hF;
        seg_n_d = SEG_BLANK;
        dp_n_d  = 1'b1;
        if (slot_q == SLOT_ON) begin
            an_n_d  = ~(4'b0001 << digit_q);
            seg_n_d = dec_seg_n;
            dp_n_d  = !(DP_EN && (digit_q == DP_IDX));
        end
        frame_strobe_d   = started_q && (tick_q == '0) && (digit_q == 2'd0);
        update_pending_d = pend_v_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q           <= '0;
            digit_q          <= 2'd0;
            display_q        <= 16'h0000;
            pending_q        <= 16'h0000;
            pend_v_q         <= 1'b0;
            trig_q           <= 1'b0;
            started_q        <= 1'b0;
            an_n_q           <= 4'hF;
            seg_n_q          <= SEG_BLANK;
            dp_n_q           <= 1'b1;
            frame_strobe_q   <= 1'b0;
            update_pending_q <= 1'b0;
        end else begin
            tick_q           <= tick_d;
            digit_q          <= digit_d;
            display_q        <= display_d;
            pending_q        <= pending_d;
            pend_v_q         <= pend_v_d;
            trig_q           <= trig_d;
            started_q        <= started_d;
            an_n_q           <= an_n_d;
            seg_n_q          <= seg_n_d;
            dp_n_q           <= dp_n_d;
            frame_strobe_q   <= frame_strobe_d;
            update_pending_q <= update_pending_d;
        end
    end

    assign an_n           = an_n_q;
    assign seg_n          = seg_n_q;
    assign dp_n           = dp_n_q;
    assign frame_strobe   = frame_strobe_q;
    assign update_pending = update_pending_q;

endmodule

// File: tb/tb_bcd_seg7_display.sv
// Directed bench for bcd_seg7_display: 8-tick slots, 2-tick gap, one DUT without and one with decimal point.
module tb_bcd_seg7_display;

    localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001, G5 = 7'b0010010, G6 = 7'b0000010, G7 = 7'b1111000;
    localparam logic [6:0] G8 = 7'b0000000, G9 = 7'b0010000, GD = 7'b0111111, GB = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bcd_values;
    logic        new_data_triger;
    logic        blank_lz;
    logic [6:0]  seg_n, seg_n1;
    logic        dp_n, dp_n1;
    logic [3:0]  an_n, an_n1;
    logic        frame_strobe, frame_strobe1;
    logic        update_pending, update_pending1;

    int n_tests = 0;
    int n_fail  = 0;
    int pos     = 0;
    int wcnt;

    always #5 clk = ~clk;

    bcd_seg7_display #(.DIGIT_TICKS(8), .GAP_TICKS(2), .DP_DIGIT(4)) dut (
        .clk(clk), .rst(rst), .bcd_values(bcd_values), .new_data_triger(new_data_triger),
        .blank_lz(blank_lz), .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n),
        .frame_strobe(frame_strobe), .update_pending(update_pending)
    );

    bcd_seg7_display #(.DIGIT_TICKS(8), .GAP_TICKS(2), .DP_DIGIT(1)) dut_dp1 (
        .clk(clk), .rst(rst), .bcd_values(bcd_values), .new_data_triger(new_data_triger),
        .blank_lz(blank_lz), .seg_n(seg_n1), .dp_n(dp_n1), .an_n(an_n1),
        .frame_strobe(frame_strobe1), .update_pending(update_pending1)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        pos += n;
    endtask

    task automatic goto_pos(input int t);
        if (t > pos) step(t - pos);
    endtask

    task automatic wait_strobe(output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (frame_strobe !== 1'b1 && n < 80);
        chk("strobe_seen", {15'd0, frame_strobe}, 16'd1);
        pos = 0;
    endtask

    task automatic load(input logic [15:0] v);
        bcd_values      = v;
        new_data_triger = 1'b1;
        step(1);
        new_data_triger = 1'b0;
        step(1);
        chk($sformatf("upd_after_load_%h", v), {15'd0, update_pending}, 16'd1);
    endtask

    task automatic check_digit(input int d, input logic [6:0] s, input logic [6:0] s1);
        goto_pos(8 * d + 1);
        chk($sformatf("gap_an_d%0d", d), {12'd0, an_n}, 16'hF);
        chk($sformatf("gap_seg_d%0d", d), {9'd0, seg_n}, {9'd0, GB});
        chk($sformatf("gap_dp1_d%0d", d), {15'd0, dp_n1}, 16'd1);
        goto_pos(8 * d + 2);
        chk($sformatf("on_an_d%0d", d), {12'd0, an_n}, {12'd0, ~(4'b0001 << d)});
        chk($sformatf("on_seg_d%0d", d), {9'd0, seg_n}, {9'd0, s});
        chk($sformatf("on_dp_d%0d", d), {15'd0, dp_n}, 16'd1);
        chk($sformatf("on_an1_d%0d", d), {12'd0, an_n1}, {12'd0, ~(4'b0001 << d)});
        chk($sformatf("on_seg1_d%0d", d), {9'd0, seg_n1}, {9'd0, s1});
        chk($sformatf("on_dp1_d%0d", d), {15'd0, dp_n1}, (d == 1) ? 16'd0 : 16'd1);
    endtask

    // e/e1 = {d3,d2,d1,d0} glyphs for the DP_DIGIT=4 and DP_DIGIT=1 instances
    task automatic frame_check(input logic [27:0] e, input logic [27:0] e1);
        chk("strobe_gap_an", {12'd0, an_n}, 16'hF);
        chk("strobe_upd", {15'd0, update_pending}, 16'd0);
        goto_pos(1);
        chk("strobe_pulse_end", {15'd0, frame_strobe}, 16'd0);
        for (int d = 0; d < 4; d++) begin
            check_digit(d, e[7*d +: 7], e1[7*d +: 7]);
        end
    endtask

    initial begin
        rst             = 1'b1;
        bcd_values      = 16'h0000;
        new_data_triger = 1'b0;
        blank_lz        = 1'b0;

        // reset
        step(3);
        chk("rst_an", {12'd0, an_n}, 16'hF);
        chk("rst_seg", {9'd0, seg_n}, 16'h7F);
        chk("rst_dp", {15'd0, dp_n}, 16'd1);
        chk("rst_fs", {15'd0, frame_strobe}, 16'd0);
        chk("rst_upd", {15'd0, update_pending}, 16'd0);
        rst = 1'b0;
        step(2);
        chk("rel_gap_an", {12'd0, an_n}, 16'hF);
        step(1);
        chk("rel_first_on_an", {12'd0, an_n}, 16'hE);
        chk("rel_first_on_seg", {9'd0, seg_n}, {9'd0, G0});

        // 1234
        load(16'h1234);
        wait_strobe(wcnt);
        frame_check({G1, G2, G3, G4}, {G1, G2, G3, G4});

        // mid-frame update must not tear the current frame
        wait_strobe(wcnt);
        goto_pos(10);
        bcd_values      = 16'h5678;
        new_data_triger = 1'b1;
        step(1);
        new_data_triger = 1'b0;
        goto_pos(12);
        chk("mid_upd", {15'd0, update_pending}, 16'd1);
        check_digit(2, G2, G2);
        check_digit(3, G1, G1);
        wait_strobe(wcnt);
        frame_check({G5, G6, G7, G8}, {G5, G6, G7, G8});

        // leading-zero blanking
        blank_lz = 1'b1;
        load(16'h0007);
        wait_strobe(wcnt);
        frame_check({GB, GB, GB, G7}, {GB, GB, G0, G7});
        load(16'h0000);
        wait_strobe(wcnt);
        frame_check({GB, GB, GB, G0}, {GB, GB, G0, G0});

        // invalid digits show a dash and are never blanked
        load(16'h12A4);
        wait_strobe(wcnt);
        frame_check({G1, G2, GD, G4}, {G1, G2, GD, G4});
        load(16'h0A00);
        wait_strobe(wcnt);
        frame_check({GB, GD, G0, G0}, {GB, GD, G0, G0});

        // rise exactly on the boundary cycle goes straight to display
        goto_pos(30);
        bcd_values      = 16'h9999;
        new_data_triger = 1'b1;
        step(1);
        new_data_triger = 1'b0;
        chk("bnd_upd_a", {15'd0, update_pending}, 16'd0);
        wait_strobe(wcnt);
        chk("bnd_strobe_next", wcnt[15:0], 16'd1);
        frame_check({G9, G9, G9, G9}, {G9, G9, G9, G9});
        chk("bnd_upd_b", {15'd0, update_pending}, 16'd0);

        // mid-frame reset discards a pending value
        wait_strobe(wcnt);
        goto_pos(10);
        load(16'h4321);
        goto_pos(13);
        rst = 1'b1;
        step(1);
        chk("mrst_an", {12'd0, an_n}, 16'hF);
        chk("mrst_seg", {9'd0, seg_n}, 16'h7F);
        chk("mrst_dp", {15'd0, dp_n}, 16'd1);
        chk("mrst_fs", {15'd0, frame_strobe}, 16'd0);
        chk("mrst_upd", {15'd0, update_pending}, 16'd0);
        chk("mrst_an1", {12'd0, an_n1}, 16'hF);
        rst = 1'b0;
        step(2);
        chk("mrel_gap_an", {12'd0, an_n}, 16'hF);
        step(1);
        chk("mrel_on_an", {12'd0, an_n}, 16'hE);
        chk("mrel_on_seg", {9'd0, seg_n}, {9'd0, G0});
        wait_strobe(wcnt);
        chk("mrel_first_strobe_delay", wcnt[15:0], 16'd30);
        frame_check({GB, GB, GB, G0}, {GB, GB, G0, G0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
